// File: rtl/mu_error_gen.sv
// ---------------------------------------------------------------------------
// mu_error_gen
//   Forms the scaled adaptation error mu*e[n] = MU*(d[n]-y[n]) for the
//   weight/control-point update blocks. Two-stage pipeline, one sample per
//   cycle, no backpressure:
//     stage 1: e = sat(d - y), registered with valid and adapt_en
//     stage 2: mu_error = adapt_en ? sat(round(e*MU >> QP)) : 0, error = e
//   Optional windowed MSE monitor, built only when MU_ERROR_MSE_EN is
//   defined; otherwise mse/mse_valid are tied to 0.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   in_valid   in   d_n/y_n/adapt_en valid this cycle
//   d_n        in   desired response d[n] (signed Q(WIDTH-QP).QP)
//   y_n        in   filter output y[n]
//   adapt_en   in   1: pass mu*e, 0: force mu_error to 0 for this sample
//   out_valid  out  in_valid delayed by 2 cycles
//   error      out  saturated e[n], held when out_valid=0
//   mu_error   out  saturated, rounded MU*e[n], held when out_valid=0
//   mse        out  mean of (e*e)>>QP over 2^WIN_LOG2 samples, held
//   mse_valid  out  one-cycle pulse when mse updates
// ---------------------------------------------------------------------------
module mu_error_gen #(
    parameter int               WIDTH    = 16,
    parameter int               QP       = 12,
    parameter logic [WIDTH-1:0] MU       = 'h0020,
    parameter int               WIN_LOG2 = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] d_n,
    input  logic [WIDTH-1:0] y_n,
    input  logic             adapt_en,
    output logic             out_valid,
    output logic [WIDTH-1:0] error,
    output logic [WIDTH-1:0] mu_error,
    output logic [WIDTH-1:0] mse,
    output logic             mse_valid
);

    localparam int STAGES = 2;
    localparam int PW     = 2 * WIDTH;
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [PW-1:0] RND = PW'(1) << (QP - 1);

    // valid shift register; bit k = sample valid after stage k
    logic [STAGES:1] vld_pipe;

    // ---------------- stage 1: saturated difference ----------------
    logic signed [WIDTH:0]   e_full;
    logic        [WIDTH-1:0] e_sat;
    logic        [WIDTH-1:0] e_d1;
    logic                    adapt_d1;

    always_comb begin
        e_full = $signed({d_n[WIDTH-1], d_n}) - $signed({y_n[WIDTH-1], y_n});
        // top two bits disagree -> result does not fit WIDTH bits
        if (e_full[WIDTH] != e_full[WIDTH-1])
            e_sat = e_full[WIDTH] ? SMIN : SMAX;
        else
            e_sat = e_full[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe[1] <= 1'b0;
            e_d1        <= '0;
            adapt_d1    <= 1'b0;
        end else begin
            vld_pipe[1] <= in_valid;
            if (in_valid) begin
                e_d1     <= e_sat;
                adapt_d1 <= adapt_en;
            end
        end
    end

    // ---------------- stage 2: scale, round, saturate ----------------
    logic signed [PW-1:0]          prod;
    logic signed [PW-1:0]          rnd;
    logic        [PW-QP-WIDTH:0]   rnd_hi;
    logic        [WIDTH-1:0]       mu_sat;
    logic        [QP-1:0]          unused_rnd_frac;

    always_comb begin
        prod   = $signed(e_d1) * $signed(MU);
        rnd    = prod + RND;
        // bits above the kept field plus its sign bit must all match
        rnd_hi = rnd[PW-1:QP+WIDTH-1];
        if ((&rnd_hi) || !(|rnd_hi))
            mu_sat = rnd[QP +: WIDTH];
        else
            mu_sat = rnd[PW-1] ? SMIN : SMAX;
    end

    // fraction bits are consumed only through the rounding add
    assign unused_rnd_frac = rnd[QP-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe[2] <= 1'b0;
            error       <= '0;
            mu_error    <= '0;
        end else begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
                error    <= e_d1;
                mu_error <= adapt_d1 ? mu_sat : '0;
            end
        end
    end

    assign out_valid = vld_pipe[STAGES];

`ifdef MU_ERROR_MSE_EN
    // ---------------- windowed MSE monitor ----------------
    // Accumulates alongside stage 2 so the update lands with that
    // sample's out_valid. adapt_en deliberately does not gate it.
    localparam int ACC_W = PW + WIN_LOG2;

    logic [ACC_W-1:0]    acc;
    logic [WIN_LOG2-1:0] cnt;
    logic signed [PW-1:0] sq_full;
    logic [ACC_W-1:0]    sq_ext;
    logic [ACC_W-1:0]    acc_sum;
    logic [ACC_W-1:0]    acc_avg;
    logic [WIDTH-1:0]    mse_next;

    always_comb begin
        sq_full  = $signed(e_d1) * $signed(e_d1);
        // e*e is never negative, so a logical shift is exact
        sq_ext   = ACC_W'(sq_full) >> QP;
        acc_sum  = acc + sq_ext;
        acc_avg  = acc_sum >> WIN_LOG2;
        mse_next = (|acc_avg[ACC_W-1:WIDTH-1]) ? SMAX : acc_avg[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            mse       <= '0;
            mse_valid <= 1'b0;
        end else begin
            mse_valid <= 1'b0;
            if (vld_pipe[1]) begin
                if (&cnt) begin
                    mse       <= mse_next;
                    mse_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
`else
    assign mse       = '0;
    assign mse_valid = 1'b0;
`endif

endmodule

// File: tb/tb_mu_error_gen.sv
// ---------------------------------------------------------------------------
// tb_mu_error_gen
//   Scoreboard bench for mu_error_gen (WIDTH=16, QP=12, MU=0x0020,
//   WIN_LOG2=8). The driver pushes the expected error/mu_error and the
//   expected output cycle for every accepted sample; the monitor pops and
//   compares on each out_valid. The MSE expectation is recomputed from the
//   popped error values when MU_ERROR_MSE_EN is defined, otherwise mse and
//   mse_valid must stay 0.
// ---------------------------------------------------------------------------
module tb_mu_error_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] d_n = '0;
    logic [15:0] y_n = '0;
    logic        adapt_en = 1'b0;
    logic        out_valid;
    logic [15:0] error;
    logic [15:0] mu_error;
    logic [15:0] mse;
    logic        mse_valid;

    mu_error_gen #(.WIDTH(16), .QP(12), .MU(16'h0020), .WIN_LOG2(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .d_n      (d_n),
        .y_n      (y_n),
        .adapt_en (adapt_en),
        .out_valid(out_valid),
        .error    (error),
        .mu_error (mu_error),
        .mse      (mse),
        .mse_valid(mse_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [15:0] e;
        logic [15:0] m;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    // reference model
    function automatic logic [15:0] e_model(input logic [15:0] d, input logic [15:0] y);
        int s;
        s = int'($signed(d)) - int'($signed(y));
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    function automatic logic [15:0] mu_model(input logic [15:0] e, input logic a);
        int p;
        p = (int'($signed(e)) * 32 + 2048) >>> 12;
        if (p > 32767) p = 32767;
        else if (p < -32768) p = -32768;
        return a ? 16'(p) : 16'h0000;
    endfunction

    // MSE model state (cleared by reset)
    longint macc = 0;
    int     mcnt = 0;
    logic [15:0] exp_mse = '0;
    int     mse_pulses = 0;

    // ---------------- monitor ----------------
    exp_t   mx;
    logic   ev;
    longint es, sq, mm;

    always @(negedge clk) begin
        if (!reset) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                chk("missing_out", 32'd0, 32'd1);
                mx = sb.pop_front();
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 32'd1, 32'd0);
                end else begin
                    mx = sb.pop_front();
                    chk("latency", cyc, mx.cyc);
                    chk("error", {16'h0, error}, {16'h0, mx.e});
                    chk("mu_error", {16'h0, mu_error}, {16'h0, mx.m});
                    ev = 1'b0;
`ifdef MU_ERROR_MSE_EN
                    es = longint'($signed(mx.e));
                    sq = (es * es) >> 12;
                    if (mcnt == 255) begin
                        mm = (macc + sq) >> 8;
                        if (mm > 32767) mm = 32767;
                        exp_mse = 16'(mm);
                        macc = 0;
                        mcnt = 0;
                        ev = 1'b1;
                    end else begin
                        macc = macc + sq;
                        mcnt++;
                    end
`endif
                    chk("mse_valid", {31'h0, mse_valid}, {31'h0, ev});
                    chk("mse", {16'h0, mse}, {16'h0, exp_mse});
                    if (mse_valid) mse_pulses++;
                end
            end else begin
                chk("mse_valid_idle", {31'h0, mse_valid}, 32'd0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [15:0] d, input logic [15:0] y, input logic a,
                        input bit use_model, input logic [15:0] xe, input logic [15:0] xm);
        exp_t t;
        @(negedge clk);
        in_valid = 1'b1;
        d_n = d;
        y_n = y;
        adapt_en = a;
        t.e   = use_model ? e_model(d, y) : xe;
        t.m   = use_model ? mu_model(t.e, a) : xm;
        t.cyc = cyc + 2;
        sb.push_back(t);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            adapt_en = 1'b0;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb.size() > 0 && budget < 20) begin
            @(negedge clk);
            in_valid = 1'b0;
            budget++;
        end
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_out_valid"}, {31'h0, out_valid}, 32'd0);
        chk({tag, "_error"}, {16'h0, error}, 32'd0);
        chk({tag, "_mu_error"}, {16'h0, mu_error}, 32'd0);
        chk({tag, "_mse"}, {16'h0, mse}, 32'd0);
        chk({tag, "_mse_valid"}, {31'h0, mse_valid}, 32'd0);
    endtask

    initial begin
        // reset state
        #3;
        check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // MSE window: 256 samples with e = 0x0100 (sq = 0x10)
        for (int i = 0; i < 256; i++)
            send(16'h0300, 16'h0200, 1'b1, 1'b0, 16'h0100, 16'h0002);
        idle(1);
        drain();
`ifdef MU_ERROR_MSE_EN
        chk("mse_win1", {16'h0, mse}, 32'h0010);
        chk("mse_pulses_win1", mse_pulses, 32'd1);
`else
        chk("mse_off", {16'h0, mse}, 32'h0000);
        chk("mse_pulses_off", mse_pulses, 32'd0);
`endif

        // directed values
        send(16'h1000, 16'h0800, 1'b1, 1'b0, 16'h0800, 16'h0010);  // basic
        idle(3);
        send(16'h0040, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0001);  // round up
        send(16'h003F, 16'h0000, 1'b1, 1'b0, 16'h003F, 16'h0000);  // round down
        send(16'h7000, 16'h9000, 1'b1, 1'b0, 16'h7FFF, 16'h0100);  // +sat
        send(16'h8000, 16'h7FFF, 1'b1, 1'b0, 16'h8000, 16'hFF00);  // -sat
        send(16'h1000, 16'h0800, 1'b0, 1'b0, 16'h0800, 16'h0000);  // gated
        idle(2);

        // gate/stream: 10 back-to-back, adapt_en alternating, then a gap
        for (int i = 0; i < 10; i++)
            send(16'(i * 16'h0123 - 16'h0400), 16'(16'h0200 - i * 16'h0031),
                 (i % 2) == 0, 1'b1, '0, '0);
        idle(1);
        send(16'hF000, 16'h0100, 1'b1, 1'b1, '0, '0);
        idle(1);
        send(16'h0100, 16'hF000, 1'b1, 1'b1, '0, '0);
        drain();

        // random stream, then asynchronous reset between edges
        for (int i = 0; i < 100; i++)
            send(16'($urandom), 16'($urandom), 1'($urandom), 1'b1, '0, '0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        check_zero("async_reset");
        sb.delete();
        macc = 0;
        mcnt = 0;
        exp_mse = '0;
        mse_pulses = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // fresh window after reset: e = 0x0200 -> sq = 0x40 -> mse = 0x40
        for (int i = 0; i < 256; i++)
            send(16'h0100, 16'hFF00, 1'b1, 1'b0, 16'h0200, 16'h0004);
        idle(1);
        drain();
`ifdef MU_ERROR_MSE_EN
        chk("mse_after_reset", {16'h0, mse}, 32'h0040);
        chk("mse_pulses_after_reset", mse_pulses, 32'd1);
`else
        chk("mse_off_after_reset", {16'h0, mse}, 32'h0000);
        chk("mse_pulses_off_after_reset", mse_pulses, 32'd0);
`endif
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // hard stop so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
